// File: rtl/ring_osc_freq_meter_pkg.sv
// Shared types and constants for the ring oscillator frequency meter.
package ring_osc_freq_meter_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meter_state_t;

    // Depth of the synchronizer on the asynchronous oscillator input.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ring_osc_freq_meter_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit into the clk domain.
module sync_2ff
    import ring_osc_freq_meter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage_reg;

    // Shift the asynchronous input through the metastability chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Ring oscillator frequency meter: enables the oscillator, waits a settle
// interval, counts synchronized rising edges over a fixed clk window and
// reports the count with a one-cycle valid strobe.
// Optional threshold check enabled by RING_OSC_FREQ_METER_RANGE_CHECK_EN.
module ring_osc_freq_meter
    import ring_osc_freq_meter_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64,
    parameter int WINDOW_CYCLES = 1024,
    parameter int COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               osc_in,
    output logic               osc_en,
    output logic               busy,
    output logic               valid,
    output logic [COUNT_W-1:0] count,
    output logic               saturated
`ifdef RING_OSC_FREQ_METER_RANGE_CHECK_EN
    ,
    input  logic [COUNT_W-1:0] lo_th,
    input  logic [COUNT_W-1:0] hi_th,
    output logic               in_range
`endif
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    meter_state_t       state_reg;
    logic [SET_W-1:0]   settle_cnt_reg;
    logic [WIN_W-1:0]   win_cnt_reg;
    logic [COUNT_W-1:0] edge_cnt_reg;
    logic [COUNT_W-1:0] edge_cnt_next;
    logic               osc_sync;
    logic               osc_prev_reg;
    logic               osc_rise;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (osc_in),
        .q     (osc_sync)
    );

    // History flop for rising-edge detection on the synchronized oscillator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            osc_prev_reg <= 1'b0;
        end else begin
            osc_prev_reg <= osc_sync;
        end
    end

    assign osc_rise = osc_sync & ~osc_prev_reg;

    // Saturating increment; the final-cycle edge is folded into the result.
    always_comb begin
        edge_cnt_next = edge_cnt_reg;
        if (osc_rise && (edge_cnt_reg != CNT_MAX)) begin
            edge_cnt_next = edge_cnt_reg + COUNT_W'(1);
        end
    end

    // Sequencer with registered outputs; abort beats every other transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= '0;
            win_cnt_reg    <= '0;
            edge_cnt_reg   <= '0;
            osc_en         <= 1'b0;
            busy           <= 1'b0;
            valid          <= 1'b0;
            count          <= '0;
            saturated      <= 1'b0;
`ifdef RING_OSC_FREQ_METER_RANGE_CHECK_EN
            in_range       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_reg      <= ST_SETTLE;
                        settle_cnt_reg <= SET_W'(SETTLE_CYCLES - 1);
                        osc_en         <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        osc_en    <= 1'b0;
                        busy      <= 1'b0;
                    end else if (settle_cnt_reg == '0) begin
                        state_reg    <= ST_MEASURE;
                        edge_cnt_reg <= '0;
                        win_cnt_reg  <= WIN_W'(WINDOW_CYCLES - 1);
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - SET_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        osc_en    <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        edge_cnt_reg <= edge_cnt_next;
                        if (win_cnt_reg == '0) begin
                            state_reg <= ST_DONE;
                            osc_en    <= 1'b0;
                            valid     <= 1'b1;
                            count     <= edge_cnt_next;
                            saturated <= (edge_cnt_next == CNT_MAX);
`ifdef RING_OSC_FREQ_METER_RANGE_CHECK_EN
                            in_range  <= (edge_cnt_next >= lo_th) &&
                                         (edge_cnt_next <= hi_th);
`endif
                        end else begin
                            win_cnt_reg <= win_cnt_reg - WIN_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    valid     <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    osc_en    <= 1'b0;
                    busy      <= 1'b0;
                    valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ring_osc_freq_meter.md
# ring_osc_freq_meter

Measures the frequency of a free-running ring oscillator output against the system clock. The block enables the oscillator, waits a settle interval, then counts synchronized rising edges of the oscillator output over a fixed window of system clocks, and reports the count with a one-cycle valid strobe. It is the consuming/measuring end of the oscillator's `enable`/`clk_out` interface and sits in the clock-network characterization and health-monitor path.

## Interface
- `SETTLE_CYCLES`, default 64: clk cycles between oscillator enable and measurement start; must be ≥1.
- `WINDOW_CYCLES`, default 1024: measurement gate length in clk cycles; must be ≥1.
- `COUNT_W`, default 16: edge-count width.
- `clk` input 1: single system clock; all logic on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: request one measurement; sampled only in IDLE.
- `abort` input 1: cancel a measurement in progress.
- `osc_in` input 1: oscillator `clk_out`, asynchronous to `clk`.
- `osc_en` output 1: drives the oscillator `enable`.
- `busy` output 1: high in SETTLE, MEASURE and DONE.
- `valid` output 1: one-cycle result strobe.
- `count` output COUNT_W: last completed edge count; held until the next completed measurement.
- `saturated` output 1: last result hit the all-ones count.
- `lo_th`, `hi_th` input COUNT_W each; `in_range` output 1: present only with the range-check macro.

## Operation
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE -> SETTLE when `start`=1. Settle counter loads SETTLE_CYCLES-1.
- SETTLE -> MEASURE when the settle counter reaches 0. The edge counter clears on entry to MEASURE.
- MEASURE -> DONE after exactly WINDOW_CYCLES cycles in MEASURE.
- DONE -> IDLE unconditionally after one cycle.
- `osc_en`=1 in SETTLE and MEASURE only; 0 in IDLE and DONE.
- `osc_in` passes through a 2-flop synchronizer, then a history flop.
  - Rising edge = sync_out & ~prev.
  - An edge increments the counter only while in MEASURE.
  - The synchronizer runs in every state.
- The edge counter saturates at 2^COUNT_W-1 and never wraps.
- In DONE: `count` and `saturated` are updated, and `valid`=1 for that single cycle.
- `abort`=1 in SETTLE or MEASURE forces IDLE next cycle: no `valid`, `count`/`saturated` unchanged. `abort` in IDLE or DONE has no effect.
- `abort` and `start` both high in IDLE: `abort` has priority; stay in IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `osc_in` faster than clk/2 is out of spec and gives undefined counts, but never a hang.

## Timing
- Reset (rst_n=0 at a clk edge): state IDLE; `osc_en`=0, `busy`=0, `valid`=0, `count`=0, `saturated`=0, `in_range`=0; synchronizer and history flops cleared.
- Reset mid-measurement behaves identically: the result is discarded.
- `start` high at edge k: SETTLE from cycle k+1; MEASURE occupies cycles k+1+SETTLE_CYCLES through k+SETTLE_CYCLES+WINDOW_CYCLES.
- `valid` is high in cycle k+1+SETTLE_CYCLES+WINDOW_CYCLES; IDLE resumes the cycle after.
- A new `start` can be accepted on the first IDLE cycle after DONE.
- Edge-detection latency is 3 clk cycles from the `osc_in` transition. Edges arriving within 3 cycles of the window boundaries may fall on either side; ±1 count is allowed.

## Configuration
- `RING_OSC_FREQ_METER_RANGE_CHECK_EN` defined:
  - `lo_th`, `hi_th` and `in_range` ports exist.
  - In DONE, `in_range` is registered as 1 iff lo_th ≤ final count ≤ hi_th (unsigned, inclusive). A saturated result compares as the all-ones value.
  - `in_range` holds with `count`.
- Not defined: those ports and the comparison logic are absent; all other behaviour is identical.

## Structure
- `ring_osc_freq_meter_pkg` holds the FSM state enum and the `SYNC_STAGES`=2 constant.
- One sub-module, `sync_2ff`: a parameter-free 2-flop synchronizer with synchronous active-low reset, instantiated for `osc_in`.

## Test plan
- `osc_in` period 8 clk, SETTLE_CYCLES=4, WINDOW_CYCLES=1024, pulse `start`:
  - `osc_en` rises 1 cycle after `start`.
  - `valid` pulses exactly 1029 cycles after `start`.
  - `count`=128±1, `saturated`=0.
- `osc_in` held at 0 -> `count`=0, `valid` pulses once.
- COUNT_W=4, `osc_in` period 8, WINDOW_CYCLES=1024 -> `count`=15, `saturated`=1, no wrap.
- `abort` asserted 100 cycles into MEASURE after a prior result of 128:
  - No `valid`; `count` stays 128.
  - `osc_en`=0 next cycle; IDLE.
- `rst_n`=0 mid-MEASURE -> all outputs 0 the next cycle. `start` pulsed while `busy` -> ignored: exactly one `valid`.
- With the range-check macro: `lo_th`=120, `hi_th`=136, period 8 -> `in_range`=1; period 16 (count 64) -> `in_range`=0.
